fir_mac_sequencer: RTL

- Controller that sequences the shared single-multiplier FIR MAC datapath: one sample in, TAPS multiply-accumulate cycles, one result out.
- Owns the circular delay-line write pointer.
- Generates coefficient-ROM and delay-line RAM addresses, accumulator clear/enable strobes, the output-register load strobe and the latched tone-select for the coefficient ROM.
- Sits between the sample source (ADC/codec interface) and the FIR datapath; replaces free-running tap counting with a handshaked, sample-synchronous schedule.

---
 rtl/fir_mac_sequencer_if.sv | 35 +++
 rtl/fir_mac_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Handshake and datapath-control bundle between the sample source, the FIR
// MAC datapath and the sequencer that schedules them.
interface fir_mac_sequencer_if #(
  parameter int ADDR_BITS = 6
) ();

  logic                 sample_valid;
  logic                 sample_ready;
  logic                 tone_sel;
  logic                 overrun_clr;
  logic                 data_wr_en;
  logic [ADDR_BITS-1:0] data_wr_addr;
  logic [ADDR_BITS-1:0] data_rd_addr;
  logic [ADDR_BITS-1:0] coef_addr;
  logic                 tone_sel_q;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 out_load;
  logic                 busy;
  logic                 overrun;

  // The source/datapath side offers samples and consumes the control strobes.
  modport master (
    output sample_valid, tone_sel, overrun_clr,
    input  sample_ready, data_wr_en, data_wr_addr, data_rd_addr, coef_addr,
           tone_sel_q, acc_clr, acc_en, out_load, busy, overrun
  );

  modport slave (
    input  sample_valid, tone_sel, overrun_clr,
    output sample_ready, data_wr_en, data_wr_addr, data_rd_addr, coef_addr,
           tone_sel_q, acc_clr, acc_en, out_load, busy, overrun
  );

endinterface

// File: rtl/fir_mac_sequencer.sv
// Sample-synchronous scheduler for a single-multiplier FIR MAC datapath:
// one accepted sample, TAPS multiply-accumulate cycles, one output load.
module fir_mac_sequencer #(
  parameter int TAPS      = 64,
  parameter int ADDR_BITS = 6,
  parameter int MAC_LAT   = 1
) (
  input logic                clk,
  input logic                reset,
  fir_mac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    MAC,
    FLUSH,
    LOAD
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_TAP   = ADDR_BITS'(TAPS - 1);
  localparam logic [1:0]           FLUSH_LAST = (MAC_LAT > 0) ? 2'(MAC_LAT - 1) : 2'd0;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_BITS-1:0] wp;
  logic [ADDR_BITS-1:0] wp_nxt;
  logic [ADDR_BITS-1:0] k;
  logic [ADDR_BITS-1:0] k_nxt;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS-1:0] rd_addr_nxt;
  logic [1:0]           flush_cnt;
  logic [1:0]           flush_cnt_nxt;
  logic                 tone_q;
  logic                 tone_q_nxt;
  logic                 ovr;
  logic                 ovr_nxt;
  logic                 accept;
  logic                 overrun_evt;

  logic                 ready_q;
  logic                 busy_q;
  logic                 wr_en_q;
  logic                 acc_en_q;
  logic                 acc_clr_q;
  logic                 load_q;
  logic                 ready_nxt;
  logic                 busy_nxt;
  logic                 wr_en_nxt;
  logic                 acc_en_nxt;
  logic                 acc_clr_nxt;
  logic                 load_nxt;

  // Next-state, counters and the registered-output decode all come from the
  // next state, so every strobe lines up with the state it belongs to.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    flush_cnt_nxt = flush_cnt;
    accept        = (state == IDLE) && bus.sample_valid;
    overrun_evt   = (state != IDLE) && bus.sample_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = MAC;
        k_nxt     = '0;
      end
      MAC: begin
        if (k == LAST_TAP) begin
          if (MAC_LAT == 0) begin
            state_nxt = LOAD;
          end else begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = '0;
          end
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt = LOAD;
        end else begin
          flush_cnt_nxt = flush_cnt + 1'b1;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    wp_nxt      = (state == LOAD) ? wp + 1'b1 : wp;
    rd_addr_nxt = (state_nxt == MAC) ? wp - k_nxt : rd_addr;
    tone_q_nxt  = accept ? bus.tone_sel : tone_q;

    // A fresh overrun beats a simultaneous clear so no event is ever lost.
    if (overrun_evt) begin
      ovr_nxt = 1'b1;
    end else if (bus.overrun_clr) begin
      ovr_nxt = 1'b0;
    end else begin
      ovr_nxt = ovr;
    end

    ready_nxt   = (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE);
    wr_en_nxt   = (state_nxt == WRITE);
    acc_en_nxt  = (state_nxt == MAC);
    acc_clr_nxt = (state_nxt == MAC) && (k_nxt == '0);
    load_nxt    = (state_nxt == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wp        <= '0;
      k         <= '0;
      rd_addr   <= '0;
      flush_cnt <= '0;
      tone_q    <= 1'b0;
      ovr       <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wp        <= wp_nxt;
      k         <= k_nxt;
      rd_addr   <= rd_addr_nxt;
      flush_cnt <= flush_cnt_nxt;
      tone_q    <= tone_q_nxt;
      ovr       <= ovr_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
      wr_en_q   <= wr_en_nxt;
      acc_en_q  <= acc_en_nxt;
      acc_clr_q <= acc_clr_nxt;
      load_q    <= load_nxt;
    end
  end

  // The tap counter doubles as the coefficient address; it holds outside MAC.
  assign bus.sample_ready = ready_q;
  assign bus.busy         = busy_q;
  assign bus.data_wr_en   = wr_en_q;
  assign bus.data_wr_addr = wp;
  assign bus.data_rd_addr = rd_addr;
  assign bus.coef_addr    = k;
  assign bus.tone_sel_q   = tone_q;
  assign bus.acc_en       = acc_en_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.out_load     = load_q;
  assign bus.overrun      = ovr;

endmodule
